// File: rtl/gf180mcu_osu_sc_gp9t3v3__lshifup_hs.sv
// Core-domain receiver for words sent up through level-up cells over a 4-phase REQ/ACK handshake.
// Optional WAIT_LO timeout with sticky ERR is enabled by defining LSHIFUP_TIMEOUT_EN.
module gf180mcu_osu_sc_gp9t3v3__lshifup_hs #(
  parameter int unsigned W     = 8,
  parameter int unsigned NSYNC = 2,
  parameter int unsigned TMO   = 15
) (
  input  logic         CLK,
  input  logic         RN,
  input  logic         REQ_L,
  input  logic [W-1:0] D_L,
  output logic         ACK,
  output logic [W-1:0] Y,
  output logic         VALID,
  output logic         BUSY,
  output logic         ERR
);

  if (W < 1 || W > 32) begin : g_bad_w
    $error("W must be in 1..32");
  end
  if (NSYNC < 2 || NSYNC > 4) begin : g_bad_nsync
    $error("NSYNC must be in 2..4");
  end
  if (TMO < 1 || TMO > 255) begin : g_bad_tmo
    $error("TMO must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPT    = 2'd1,
    WAIT_LO = 2'd2
  } state_t;

  state_t           state;
  logic [NSYNC-1:0] sync;
  logic             req_s;
  logic             start_c;
  logic             tmo_hit_c;

  // REQ_L crosses into the CLK domain through a plain flop chain
  always_ff @(posedge CLK) begin
    if (!RN) begin
      sync <= '0;
    end else begin
      sync <= {sync[NSYNC-2:0], REQ_L};
    end
  end

  assign req_s = sync[NSYNC-1];

`ifdef LSHIFUP_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  logic [7:0] cnt;
  logic       req_q;

  // After a timeout req_s may still be high; only a fresh rising edge starts a transfer
  assign start_c   = req_s & ~req_q;
  assign tmo_hit_c = (state == WAIT_LO) && req_s && (cnt == TMO_LAST);

  always_ff @(posedge CLK) begin
    if (!RN) begin
      cnt   <= 8'd0;
      req_q <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      req_q <= req_s;
      if (state == CAPT) begin
        cnt <= 8'd0;
      end else if (state == WAIT_LO) begin
        cnt <= cnt + 8'd1;
      end
      if (tmo_hit_c) begin
        ERR <= 1'b1;
      end
    end
  end
`else
  assign start_c   = req_s;
  assign tmo_hit_c = 1'b0;
  assign ERR       = 1'b0;
`endif

  // Handshake FSM; Y, VALID and ACK update on the edge that enters CAPT
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state <= IDLE;
      ACK   <= 1'b0;
      Y     <= '0;
      VALID <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (start_c) begin
            state <= CAPT;
            Y     <= D_L;
            VALID <= 1'b1;
            ACK   <= 1'b1;
            BUSY  <= 1'b1;
          end
        end
        CAPT: begin
          state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!req_s || tmo_hit_c) begin
            state <= IDLE;
            ACK   <= 1'b0;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ACK   <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__lshifup_hs.sv
// Directed bench for the level-up handshake receiver; captured words are checked against a scoreboard queue.
module tb_gf180mcu_osu_sc_gp9t3v3__lshifup_hs;

  localparam int unsigned W     = 8;
  localparam int unsigned NSYNC = 2;
  localparam int unsigned TMO   = 15;

  logic         clk = 1'b0;
  logic         rn;
  logic         req_l;
  logic [W-1:0] d_l;
  logic         ack;
  logic [W-1:0] y;
  logic         valid;
  logic         busy;
  logic         err;

  int           vectors     = 0;
  int           miscompares = 0;
  int           pushed      = 0;
  int           pulses      = 0;
  logic [W-1:0] exp_q[$];
  logic         valid_d     = 1'b0;

  gf180mcu_osu_sc_gp9t3v3__lshifup_hs #(
    .W     (W),
    .NSYNC (NSYNC),
    .TMO   (TMO)
  ) dut (
    .CLK   (clk),
    .RN    (rn),
    .REQ_L (req_l),
    .D_L   (d_l),
    .ACK   (ack),
    .Y     (y),
    .VALID (valid),
    .BUSY  (busy),
    .ERR   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    exp_q.push_back(w);
    pushed++;
  endtask

  task automatic wait_ack(input logic lvl, input string tag);
    int n = 0;
    while (ack !== lvl && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(ack), 32'(lvl));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ack"},   32'(ack),   32'(1'b0));
    check({tag, "_valid"}, 32'(valid), 32'(1'b0));
    check({tag, "_busy"},  32'(busy),  32'(1'b0));
    check({tag, "_err"},   32'(err),   32'(1'b0));
  endtask

  // Scoreboard: every VALID strobe pops the oldest expected word
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      pulses++;
      check("valid_back_to_back", 32'(valid_d), 32'(1'b0));
      check("word_expected", 32'(exp_q.size() != 0), 32'(1'b1));
      if (exp_q.size() != 0) begin
        check("y_scoreboard", 32'(y), 32'(exp_q.pop_front()));
      end
    end
    valid_d = valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] stream[4];
    stream[0] = 8'h00;
    stream[1] = 8'hFF;
    stream[2] = 8'h5A;
    stream[3] = 8'hC3;

    // Reset held with REQ_L high: everything stays cleared
    rn    = 1'b0;
    req_l = 1'b1;
    d_l   = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("reset");
      check("reset_y", 32'(y), 32'(8'h00));
    end
    rn    = 1'b1;
    req_l = 1'b0;
    tick();
    tick();
    tick();
    check_idle("post_reset");

    // Single word: VALID/ACK exactly NSYNC+1 clocks after REQ_L rises
    d_l   = 8'hA5;
    req_l = 1'b1;
    push_word(8'hA5);
    tick();
    check("single_valid_c1", 32'(valid), 32'(1'b0));
    tick();
    check("single_valid_c2", 32'(valid), 32'(1'b0));
    tick();
    check("single_valid_c3", 32'(valid), 32'(1'b1));
    check("single_y", 32'(y), 32'(8'hA5));
    check("single_ack", 32'(ack), 32'(1'b1));
    check("single_busy", 32'(busy), 32'(1'b1));

    // D_L changes while REQ_L is high: Y must not follow
    d_l = 8'h11;
    tick();
    check("hold_valid", 32'(valid), 32'(1'b0));
    tick();
    check("hold_y", 32'(y), 32'(8'hA5));
    check("hold_ack", 32'(ack), 32'(1'b1));

    // REQ_L fall to ACK fall takes NSYNC+1 clocks
    req_l = 1'b0;
    tick();
    check("ackfall_c1", 32'(ack), 32'(1'b1));
    tick();
    check("ackfall_c2", 32'(ack), 32'(1'b1));
    tick();
    check("ackfall_c3", 32'(ack), 32'(1'b0));
    check("ackfall_busy", 32'(busy), 32'(1'b0));

    // Stream of four words driven as fast as the handshake allows
    for (int i = 0; i < 4; i++) begin
      d_l   = stream[i];
      req_l = 1'b1;
      push_word(stream[i]);
      wait_ack(1'b1, "stream_ack_rise");
      check("stream_y", 32'(y), 32'(stream[i]));
      req_l = 1'b0;
      wait_ack(1'b0, "stream_ack_fall");
    end
    check("stream_drained", 32'(exp_q.size()), 32'(0));

    // Reset in WAIT_LO aborts the handshake; a fresh capture follows release
    d_l   = 8'h3C;
    req_l = 1'b1;
    push_word(8'h3C);
    wait_ack(1'b1, "midrst_ack_rise");
    tick();
    tick();
    check("midrst_busy_wait", 32'(busy), 32'(1'b1));
    rn = 1'b0;
    tick();
    check_idle("midrst");
    check("midrst_y", 32'(y), 32'(8'h00));
    rn = 1'b1;
    push_word(8'h3C);
    tick();
    check("midrst_valid_c1", 32'(valid), 32'(1'b0));
    tick();
    check("midrst_valid_c2", 32'(valid), 32'(1'b0));
    tick();
    check("midrst_valid_c3", 32'(valid), 32'(1'b1));
    check("midrst_y_recap", 32'(y), 32'(8'h3C));
    check("midrst_ack", 32'(ack), 32'(1'b1));
    req_l = 1'b0;
    wait_ack(1'b0, "midrst_ack_fall");

`ifdef LSHIFUP_TIMEOUT_EN
    // REQ_L stuck high: timeout after TMO cycles in WAIT_LO, then no recapture
    d_l   = 8'h77;
    req_l = 1'b1;
    push_word(8'h77);
    wait_ack(1'b1, "tmo_ack_rise");
    for (int i = 0; i < int'(TMO); i++) tick();
    check("tmo_ack_before", 32'(ack), 32'(1'b1));
    check("tmo_err_before", 32'(err), 32'(1'b0));
    tick();
    check("tmo_ack_after", 32'(ack), 32'(1'b0));
    check("tmo_err_after", 32'(err), 32'(1'b1));
    for (int i = 0; i < 10; i++) tick();
    check("tmo_no_recap_ack", 32'(ack), 32'(1'b0));
    check("tmo_no_recap_busy", 32'(busy), 32'(1'b0));
    req_l = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    d_l   = 8'h88;
    req_l = 1'b1;
    push_word(8'h88);
    wait_ack(1'b1, "tmo_retry_ack");
    check("tmo_retry_y", 32'(y), 32'(8'h88));
    check("tmo_err_sticky", 32'(err), 32'(1'b1));
    req_l = 1'b0;
    wait_ack(1'b0, "tmo_retry_ack_fall");
`endif

    tick();
    tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'(0));
    check("final_pulse_count", 32'(pulses), 32'(pushed));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
